ca_prng_engine: RTL and testbench

CA_PRNG_ENGINE -- requirements
Module: ca_prng_engine

---
 rtl/ca_prng_engine.sv | 121 ++++++++++++
 tb/tb_ca_prng_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_prng_engine.sv
// Elementary cellular-automaton pseudo-random engine: a WIDTH-cell automaton
// driven by STEP/SEED/RUN/SET_RULE commands, with a held output window.
module ca_prng_engine #(
  parameter int WIDTH        = 64,
  parameter int OUT_W        = 4,
  parameter int OUT_LSB      = 29,
  parameter int RULE_DEFAULT = 110
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic               wrap_en,
  output logic               cmd_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               led_sig
);

  generate
    if (WIDTH < 3 || OUT_W < 1 || OUT_LSB < 0 || OUT_LSB + OUT_W > WIDTH) begin : g_bad_params
      $error("ca_prng_engine: illegal WIDTH/OUT_W/OUT_LSB combination");
    end
  endgenerate

  localparam logic [1:0] OP_STEP     = 2'b00;
  localparam logic [1:0] OP_SEED     = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_SET_RULE = 2'b11;

  // Operand widened so the 16-bit run count and 8-bit rule exist for any WIDTH.
  localparam int CW = (WIDTH > 16) ? WIDTH : 16;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [7:0]       rule;
  logic [15:0]      steps_left;
  logic [CW-1:0]    cmd_ext;
  logic [15:0]      run_n;
  logic [WIDTH+1:0] ext;

  assign cmd_ext   = CW'(cmd_data);
  assign run_n     = cmd_ext[15:0];
  assign cmd_ready = (state == ST_IDLE);

  // Cells padded with their boundary neighbours, so ext[i+:3] is {L,C,R} of cell i.
  always_comb begin
    ext = {wrap_en & q[0], q, wrap_en & q[WIDTH-1]};
    nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nxt[i] = rule[ext[i +: 3]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      q          <= '0;
      rule       <= 8'(RULE_DEFAULT);
      steps_left <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      led_sig    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            led_sig <= ~led_sig;
            case (cmd_op)
              OP_STEP: begin
                q         <= nxt;
                out_data  <= nxt[OUT_LSB +: OUT_W];
                out_valid <= 1'b1;
                state     <= ST_HOLD;
              end
              OP_SEED: q <= cmd_ext[WIDTH-1:0];
              OP_RUN: begin
                if (run_n == 16'd0) begin
                  out_data  <= q[OUT_LSB +: OUT_W];
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
                end else begin
                  steps_left <= run_n;
                  busy       <= 1'b1;
                  state      <= ST_RUN;
                end
              end
              OP_SET_RULE: rule <= cmd_ext[7:0];
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          q          <= nxt;
          steps_left <= steps_left - 16'd1;
          if (steps_left == 16'd1) begin
            out_data  <= nxt[OUT_LSB +: OUT_W];
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_prng_engine.sv
// Self-checking bench for ca_prng_engine (8 cells, full-width output window),
// using directed vector tables plus randomized commands against a reference model.
module tb_ca_prng_engine;

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_SEED = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_RULE = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       wrap_en = 1'b0;
  logic       cmd_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;
  logic       led_sig;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q = 8'h00;
  logic [7:0] model_rule = 8'd110;
  logic       model_led = 1'b0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       wrap;
    logic       has_out;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  ca_prng_engine #(
    .WIDTH(8), .OUT_W(8), .OUT_LSB(0), .RULE_DEFAULT(110)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .wrap_en(wrap_en), .cmd_ready(cmd_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .led_sig(led_sig)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One generation from the rule table: each cell looks up bit (4L+2C+R) of the rule.
  function automatic logic [7:0] ref_step(input logic [7:0] cur, input logic [7:0] r,
                                          input logic wrap);
    logic [7:0] res;
    logic [7:0] sh;
    int l, c, rr;
    res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      c  = int'(cur[i]);
      l  = (i == 7) ? (wrap ? int'(cur[0]) : 0) : int'(cur[(i + 1) % 8]);
      rr = (i == 0) ? (wrap ? int'(cur[7]) : 0) : int'(cur[(i + 7) % 8]);
      sh = r >> (4 * l + 2 * c + rr);
      res[i] = sh[0];
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one command at a falling edge and advances the model as the DUT should.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data, input logic wrap);
    int waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    wrap_en   = wrap;
    @(negedge clk);
    cmd_valid = 1'b0;
    model_led = ~model_led;
    case (op)
      OP_SEED: model_q = data;
      OP_RULE: model_rule = data;
      OP_STEP: model_q = ref_step(model_q, model_rule, wrap);
      default: ;
    endcase
    checkOutput("led_sig", 32'(led_sig), 32'(model_led));
  endtask

  task automatic collectResult(input string name, input logic [7:0] exp);
    int waited = 0;
    while (!out_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_released"}, 32'({out_valid, cmd_ready}), 32'b01);
  endtask

  task automatic runModel(input int n, input logic random_wrap);
    applyStimulus(OP_RUN, 8'(n), wrap_en);
    for (int j = 0; j < n; j++) begin
      if (random_wrap) wrap_en = 1'($urandom);
      model_q = ref_step(model_q, model_rule, wrap_en);
      @(negedge clk);
    end
    collectResult("rand_run", model_q);
  endtask

  initial begin
    int busy_cycles;
    int waited;
    logic [7:0] held;
    logic [1:0] op;
    logic [7:0] d;

    vecs[0] = '{OP_SEED, 8'h01, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{OP_STEP, 8'h00, 1'b0, 1'b1, 8'h03};
    vecs[2] = '{OP_STEP, 8'h00, 1'b0, 1'b1, 8'h07};
    vecs[3] = '{OP_STEP, 8'h00, 1'b0, 1'b1, 8'h0D};
    vecs[4] = '{OP_RULE, 8'd90, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{OP_SEED, 8'h80, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{OP_STEP, 8'h00, 1'b1, 1'b1, 8'h41};
    vecs[7] = '{OP_SEED, 8'h80, 1'b0, 1'b0, 8'h00};
    vecs[8] = '{OP_STEP, 8'h00, 1'b0, 1'b1, 8'h40};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_outputs", 32'({out_valid, busy, led_sig}), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);

    // Reset wins over a command presented on the same edge.
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_STEP;
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    checkOutput("reset_override", 32'({out_valid, led_sig, cmd_ready}), 32'b001);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].wrap);
      if (vecs[i].has_out) collectResult($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Four accepted commands bring led_sig back to where it started.
    held = 8'(led_sig);
    applyStimulus(OP_RULE, 8'd110, 1'b0);
    applyStimulus(OP_SEED, 8'h01, 1'b0);
    applyStimulus(OP_RULE, 8'd110, 1'b0);
    applyStimulus(OP_SEED, 8'h01, 1'b0);
    checkOutput("led_four_cmds", 32'(led_sig), 32'(held));

    applyStimulus(OP_RUN, 8'd3, 1'b0);
    busy_cycles = 0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      waited++;
    end
    model_q = ref_step(ref_step(ref_step(model_q, model_rule, 1'b0), model_rule, 1'b0), model_rule, 1'b0);
    checkOutput("run3_busy_cycles", 32'(busy_cycles), 32'd3);
    checkOutput("run3_busy_end", 32'(busy), 32'd0);
    collectResult("run3", 8'h0D);

    applyStimulus(OP_RUN, 8'd0, 1'b0);
    checkOutput("run0_immediate", 32'({out_valid, busy}), 32'b10);
    collectResult("run0", 8'h0D);

    // HOLD must freeze the result and ignore commands while out_ready is low.
    applyStimulus(OP_STEP, 8'h00, 1'b0);
    held = model_q;
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_state", 32'({out_valid, cmd_ready, led_sig}), 32'({1'b1, 1'b0, model_led}));
      checkOutput("hold_data", 32'(out_data), 32'(held));
      cmd_valid = (k % 2 == 1);
      cmd_op = OP_SEED;
      cmd_data = 8'hFF;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checkOutput("hold_led", 32'(led_sig), 32'(model_led));
    collectResult("hold", held);
    applyStimulus(OP_STEP, 8'h00, 1'b0);
    collectResult("after_hold", model_q);

    // A wrap change mid-RUN applies from the next generation onward.
    applyStimulus(OP_RULE, 8'd90, 1'b0);
    applyStimulus(OP_SEED, 8'h80, 1'b0);
    applyStimulus(OP_RUN, 8'd2, 1'b1);
    @(negedge clk);
    wrap_en = 1'b0;
    model_q = ref_step(ref_step(8'h80, 8'd90, 1'b1), 8'd90, 1'b0);
    collectResult("run_wrap_change", 8'hA2);

    applyStimulus(OP_RULE, 8'd30, 1'b0);
    applyStimulus(OP_SEED, 8'h5A, 1'b0);
    applyStimulus(OP_RUN, 8'd10, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_q = 8'h00; model_rule = 8'd110; model_led = 1'b0;
    checkOutput("midrun_reset_flags", 32'({out_valid, busy, led_sig, cmd_ready}), 32'b0001);
    checkOutput("midrun_reset_data", 32'(out_data), 32'd0);
    applyStimulus(OP_STEP, 8'h00, 1'b0);
    collectResult("post_reset_step", 8'h00);
    applyStimulus(OP_SEED, 8'h01, 1'b0);
    applyStimulus(OP_STEP, 8'h00, 1'b0);
    collectResult("post_reset_rule", 8'h03);

    for (int it = 0; it < 150; it++) begin
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      case (op)
        OP_STEP: begin
          applyStimulus(OP_STEP, d, 1'($urandom));
          collectResult("rand_step", model_q);
        end
        OP_RUN: runModel($urandom_range(0, 6), 1'b1);
        default: applyStimulus(op, d, 1'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
